// File: rtl/fir_feeder_if.sv
// fir_feeder_if: configuration, coefficient, sample and filter-side signals of the FIR feeder.
// master = upstream source / filter side, slave = the feeder.
// Build macro FIR_FEEDER_DECIM_EN adds the cfg_dec_level field.
interface fir_feeder_if #(
  parameter int unsigned FS_WIDTH    = 6,
  parameter int unsigned INPUT_WIDTH = 32
);
  logic                   cfg_start;
  logic [FS_WIDTH-1:0]    cfg_filter_size;
`ifdef FIR_FEEDER_DECIM_EN
  logic [1:0]             cfg_dec_level;
`endif
  logic [INPUT_WIDTH-1:0] coeff_data_in;
  logic                   coeff_valid_in;
  logic                   coeff_ready_out;
  logic [INPUT_WIDTH-1:0] sample_data_in;
  logic                   sample_valid_in;
  logic                   sample_ready_out;
  logic                   stall_in;
  logic                   flush_in;
  logic                   init_filter_out;
  logic                   input_valid_out;
  logic [INPUT_WIDTH-1:0] fir_input_out;
  logic [FS_WIDTH-1:0]    filter_size_out;
  logic                   flush_pipeline_out;
  logic                   coeffs_loaded;
  logic                   error_flag;

  modport master (
    output cfg_start, cfg_filter_size,
`ifdef FIR_FEEDER_DECIM_EN
    output cfg_dec_level,
`endif
    output coeff_data_in, coeff_valid_in, sample_data_in, sample_valid_in, stall_in, flush_in,
    input  coeff_ready_out, sample_ready_out, init_filter_out, input_valid_out, fir_input_out,
    input  filter_size_out, flush_pipeline_out, coeffs_loaded, error_flag
  );

  modport slave (
    input  cfg_start, cfg_filter_size,
`ifdef FIR_FEEDER_DECIM_EN
    input  cfg_dec_level,
`endif
    input  coeff_data_in, coeff_valid_in, sample_data_in, sample_valid_in, stall_in, flush_in,
    output coeff_ready_out, sample_ready_out, init_filter_out, input_valid_out, fir_input_out,
    output filter_size_out, flush_pipeline_out, coeffs_loaded, error_flag
  );
endinterface

// File: rtl/fir_filter_feeder.sv
// fir_filter_feeder: programs the FIR coefficient memory, then streams buffered samples.
// Build macro FIR_FEEDER_DECIM_EN enables forwarding of every 2^cfg_dec_level-th sample.
module fir_filter_feeder #(
  parameter int unsigned FS_WIDTH    = 6,
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned FIFO_AW     = 3
) (
  input logic         clk,
  input logic         rst,
  fir_feeder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STREAM = 2'd2} state_t;

  state_t                 state, state_nx;
  logic [FS_WIDTH-1:0]    size_q, coeff_cnt, coeff_cnt_nx;
  logic                   slot_valid, slot_valid_nx;
  logic [INPUT_WIDTH-1:0] slot_data, slot_data_nx;
  logic                   init_q, init_nx, loaded_q, loaded_nx;
  logic                   error_q, error_nx, flushp_q, flushp_nx;
  logic                   reload_q, reload_nx;
  logic [INPUT_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]     wptr, rptr;
  logic [CNT_W-1:0]       count, count_nx;
  logic                   full_q;
  logic                   push, pop, xfer, slot_free, cfg_ok, cfg_take, coeff_ready_c, fwd;

`ifdef FIR_FEEDER_DECIM_EN
  logic [1:0] dec_level;
  logic [2:0] phase, phase_last;

  assign phase_last = 3'((4'd1 << dec_level) - 4'd1);
  assign fwd        = (phase == 3'd0);

  // Decimation phase: restarts on LOAD entry and on flush, advances on every FIFO pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_level <= '0;
      phase     <= '0;
    end else begin
      if (cfg_take) dec_level <= bus.cfg_dec_level;
      if (bus.flush_in || (state_nx == LOAD && state != LOAD)) phase <= '0;
      else if (pop) phase <= (phase == phase_last) ? 3'd0 : phase + 3'd1;
    end
  end
`else
  assign fwd = 1'b1;
`endif

  // Next-state, slot, FIFO-pop and coefficient-handshake decisions.
  always_comb begin
    state_nx      = state;
    coeff_cnt_nx  = coeff_cnt;
    slot_valid_nx = slot_valid;
    slot_data_nx  = slot_data;
    init_nx       = init_q;
    loaded_nx     = loaded_q;
    error_nx      = error_q;
    reload_nx     = reload_q;
    flushp_nx     = 1'b0;
    cfg_take      = 1'b0;
    pop           = 1'b0;
    coeff_ready_c = 1'b0;
    xfer          = slot_valid & ~bus.stall_in;
    slot_free     = ~slot_valid | xfer;
    push          = bus.sample_valid_in & ~full_q & ~bus.flush_in;
    cfg_ok        = (bus.cfg_filter_size != '0);

    if (bus.sample_valid_in && full_q) error_nx = 1'b1;
    if (xfer) slot_valid_nx = 1'b0;

    if (bus.flush_in) begin
      slot_valid_nx = 1'b0;
      reload_nx     = 1'b0;
      flushp_nx     = 1'b1;
      if (state == LOAD) begin
        state_nx  = IDLE;
        init_nx   = 1'b0;
        loaded_nx = 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (cfg_ok) begin
              state_nx     = LOAD;
              cfg_take     = 1'b1;
              coeff_cnt_nx = '0;
              init_nx      = 1'b1;
              loaded_nx    = 1'b0;
            end else begin
              error_nx = 1'b1;
            end
          end
        end
        LOAD: begin
          // Never accept more coefficients than the latched size.
          coeff_ready_c = ~slot_valid | (xfer & (coeff_cnt != size_q - FS_WIDTH'(1)));
          if (bus.cfg_start) error_nx = 1'b1;
          if (xfer) begin
            coeff_cnt_nx = coeff_cnt + FS_WIDTH'(1);
            if (coeff_cnt == size_q - FS_WIDTH'(1)) begin
              state_nx  = STREAM;
              init_nx   = 1'b0;
              loaded_nx = 1'b1;
            end
          end
          if (bus.coeff_valid_in && coeff_ready_c) begin
            slot_valid_nx = 1'b1;
            slot_data_nx  = bus.coeff_data_in;
          end
        end
        STREAM: begin
          if (bus.cfg_start && !reload_q) begin
            if (cfg_ok) begin
              reload_nx = 1'b1;
              cfg_take  = 1'b1;
              loaded_nx = 1'b0;
            end else begin
              error_nx = 1'b1;
            end
          end
          if (reload_q) begin
            if (!slot_valid) begin
              state_nx     = LOAD;
              coeff_cnt_nx = '0;
              init_nx      = 1'b1;
              reload_nx    = 1'b0;
            end
          end else if (count != '0) begin
            if (!fwd) begin
              pop = 1'b1;
            end else if (slot_free) begin
              pop           = 1'b1;
              slot_valid_nx = 1'b1;
              slot_data_nx  = mem[rptr];
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    count_nx = bus.flush_in ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  end

  // State, slot, status and FIFO pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= '0;
      coeff_cnt  <= '0;
      slot_valid <= 1'b0;
      slot_data  <= '0;
      init_q     <= 1'b0;
      loaded_q   <= 1'b0;
      error_q    <= 1'b0;
      flushp_q   <= 1'b0;
      reload_q   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      full_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      coeff_cnt  <= coeff_cnt_nx;
      slot_valid <= slot_valid_nx;
      slot_data  <= slot_data_nx;
      init_q     <= init_nx;
      loaded_q   <= loaded_nx;
      error_q    <= error_nx;
      flushp_q   <= flushp_nx;
      reload_q   <= reload_nx;
      count      <= count_nx;
      full_q     <= (count_nx == CNT_W'(DEPTH));
      if (cfg_take) size_q <= bus.cfg_filter_size;
      if (bus.flush_in) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + FIFO_AW'(1);
        if (pop)  rptr <= rptr + FIFO_AW'(1);
      end
    end
  end

  // Sample FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.sample_data_in;
  end

  assign bus.coeff_ready_out    = coeff_ready_c;
  assign bus.sample_ready_out   = ~full_q;
  assign bus.init_filter_out    = init_q;
  assign bus.input_valid_out    = slot_valid;
  assign bus.fir_input_out      = slot_data;
  assign bus.filter_size_out    = size_q;
  assign bus.flush_pipeline_out = flushp_q;
  assign bus.coeffs_loaded      = loaded_q;
  assign bus.error_flag         = error_q;
endmodule

// File: tb/tb_fir_filter_feeder.sv
// tb_fir_filter_feeder: directed scenarios against a transaction-order model of the feeder output.
module tb_fir_filter_feeder;
  localparam int unsigned FS_WIDTH    = 6;
  localparam int unsigned INPUT_WIDTH = 32;
  localparam int unsigned FIFO_AW     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_feeder_if #(.FS_WIDTH(FS_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)) bus ();

  fir_filter_feeder #(.FS_WIDTH(FS_WIDTH), .INPUT_WIDTH(INPUT_WIDTH), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        is_coeff;
    logic [31:0] data;
  } item_t;

  item_t       exp_q[$];
  item_t       cmp_item;
  int          tests = 0;
  int          fails = 0;
  int          samp_xfers = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected filter-side order: coefficients in the order they are sent.
  function automatic void exp_coeffs(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, base + 32'(i)});
  endfunction

  // Expected samples: only every 2^level-th sample counted from the stream start survives.
  function automatic void exp_samples(input int n, input logic [31:0] base, input int level);
    for (int i = 0; i < n; i++)
      if ((i % (1 << level)) == 0) exp_q.push_back('{1'b0, base + 32'(i)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic [FS_WIDTH-1:0] size);
    bus.cfg_start       = 1'b1;
    bus.cfg_filter_size = size;
    tick();
    bus.cfg_start       = 1'b0;
  endtask

  task automatic send_coeffs(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int  t;
      logic ok;
      t  = 0;
      ok = 1'b0;
      bus.coeff_valid_in = 1'b1;
      bus.coeff_data_in  = base + 32'(i);
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = bus.coeff_ready_out;
        t++;
      end
      if (!ok) check("coeff_handshake_timeout", 64'(ok), 64'd1);
      tick();
    end
    bus.coeff_valid_in = 1'b0;
  endtask

  task automatic push_samples(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int  t;
      logic ok;
      t  = 0;
      ok = 1'b0;
      bus.sample_valid_in = 1'b1;
      bus.sample_data_in  = base + 32'(i);
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = bus.sample_ready_out;
        t++;
      end
      if (!ok) check("sample_handshake_timeout", 64'(ok), 64'd1);
      tick();
    end
    bus.sample_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Every cycle: held slot must stay stable; each transfer must match the model's next word.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(bus.input_valid_out), 64'd1);
        check("hold_data", 64'(bus.fir_input_out), 64'(hold_data));
      end
      if (bus.input_valid_out && !bus.stall_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 64'(bus.fir_input_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          cmp_item = exp_q.pop_front();
          check("xfer_data", 64'(bus.fir_input_out), 64'(cmp_item.data));
          check("xfer_init", 64'(bus.init_filter_out), 64'(cmp_item.is_coeff));
          if (!cmp_item.is_coeff) samp_xfers++;
        end
      end
      hold_prev = bus.input_valid_out & bus.stall_in & ~bus.flush_in;
      hold_data = bus.fir_input_out;
    end
  end

  initial begin
    int base_x;
    int t;
    bus.cfg_start       = 1'b0;
    bus.cfg_filter_size = '0;
    bus.coeff_data_in   = '0;
    bus.coeff_valid_in  = 1'b0;
    bus.sample_data_in  = '0;
    bus.sample_valid_in = 1'b0;
    bus.stall_in        = 1'b0;
    bus.flush_in        = 1'b0;
`ifdef FIR_FEEDER_DECIM_EN
    bus.cfg_dec_level   = 2'd0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_init", 64'(bus.init_filter_out), 64'd0);
    check("rst_valid", 64'(bus.input_valid_out), 64'd0);
    check("rst_data", 64'(bus.fir_input_out), 64'd0);
    check("rst_size", 64'(bus.filter_size_out), 64'd0);
    check("rst_flushp", 64'(bus.flush_pipeline_out), 64'd0);
    check("rst_loaded", 64'(bus.coeffs_loaded), 64'd0);
    check("rst_error", 64'(bus.error_flag), 64'd0);
    check("rst_sready", 64'(bus.sample_ready_out), 64'd1);
    check("rst_cready", 64'(bus.coeff_ready_out), 64'd0);
    tick();

    // Load 4 coefficients; fill the FIFO with 8 samples while loading
    exp_coeffs(4, 32'hA0);
    exp_samples(8, 32'h100, 0);
    pulse_cfg(6'd4);
    @(negedge clk);
    check("load_init", 64'(bus.init_filter_out), 64'd1);
    check("load_size", 64'(bus.filter_size_out), 64'd4);
    check("load_cready", 64'(bus.coeff_ready_out), 64'd1);
    tick();
    push_samples(8, 32'h100);
    @(negedge clk);
    check("fifo_full_sready", 64'(bus.sample_ready_out), 64'd0);
    check("fifo_full_loaded", 64'(bus.coeffs_loaded), 64'd0);
    tick();
    send_coeffs(4, 32'hA0);
    t = 0;
    while (!bus.coeffs_loaded && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("loaded_after_load", 64'(bus.coeffs_loaded), 64'd1);
    check("init_dropped", 64'(bus.init_filter_out), 64'd0);
    check("pop_latency_gap", 64'(bus.input_valid_out), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("throughput_valid", 64'(bus.input_valid_out), 64'd1);
    end
    @(negedge clk);
    check("stream_empty", 64'(bus.input_valid_out), 64'd0);
    check("fifo_drained_sready", 64'(bus.sample_ready_out), 64'd1);
    tick();
    wait_drain("drain_load_stream");

    // Stall for 3 cycles in the middle of a stream
    exp_samples(6, 32'h200, 0);
    base_x = samp_xfers;
    fork
      push_samples(6, 32'h200);
      begin
        int w;
        w = 0;
        while (samp_xfers < base_x + 2 && w < 50) begin
          @(negedge clk);
          w++;
        end
        tick();
        bus.stall_in = 1'b1;
        repeat (3) tick();
        bus.stall_in = 1'b0;
      end
    join
    wait_drain("drain_stall");
    check("stall_count", 64'(samp_xfers - base_x), 64'd6);

    // Reload from STREAM: slot sample first, new coefficients, then queued samples
    bus.stall_in = 1'b1;
    exp_q.push_back('{1'b0, 32'h300});
    exp_coeffs(3, 32'h30);
    exp_samples(3, 32'h301, 0);
    push_samples(4, 32'h300);
    repeat (2) tick();
    pulse_cfg(6'd3);
    @(negedge clk);
    check("reload_loaded_clr", 64'(bus.coeffs_loaded), 64'd0);
    check("reload_size", 64'(bus.filter_size_out), 64'd3);
    check("reload_slot_held", 64'(bus.fir_input_out), 64'h300);
    tick();
    bus.stall_in = 1'b0;
    send_coeffs(3, 32'h30);
    wait_drain("drain_reload");
    check("reload_loaded_set", 64'(bus.coeffs_loaded), 64'd1);

    // Flush in STREAM: buffered samples are discarded, state stays STREAM
    bus.stall_in = 1'b1;
    push_samples(3, 32'h400);
    repeat (2) tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    @(negedge clk);
    check("sflush_pulse", 64'(bus.flush_pipeline_out), 64'd1);
    check("sflush_valid", 64'(bus.input_valid_out), 64'd0);
    check("sflush_loaded", 64'(bus.coeffs_loaded), 64'd1);
    @(negedge clk);
    check("sflush_pulse_end", 64'(bus.flush_pipeline_out), 64'd0);
    tick();
    bus.stall_in = 1'b0;
    exp_q.push_back('{1'b0, 32'h4AA});
    push_samples(1, 32'h4AA);
    wait_drain("drain_after_sflush");

    // Flush in LOAD after 2 coefficients
    exp_coeffs(2, 32'h50);
    pulse_cfg(6'd5);
    send_coeffs(2, 32'h50);
    tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    @(negedge clk);
    check("lflush_init", 64'(bus.init_filter_out), 64'd0);
    check("lflush_pulse", 64'(bus.flush_pipeline_out), 64'd1);
    check("lflush_loaded", 64'(bus.coeffs_loaded), 64'd0);
    check("lflush_cready_idle", 64'(bus.coeff_ready_out), 64'd0);
    check("lflush_coeffs_sent", 64'(exp_q.size()), 64'd0);
    check("lflush_size", 64'(bus.filter_size_out), 64'd5);
    @(negedge clk);
    check("lflush_pulse_end", 64'(bus.flush_pipeline_out), 64'd0);
    tick();

    // Zero-size request in IDLE
    check("error_before", 64'(bus.error_flag), 64'd0);
    pulse_cfg(6'd0);
    @(negedge clk);
    check("error_size0", 64'(bus.error_flag), 64'd1);
    check("size0_stays_idle", 64'(bus.init_filter_out), 64'd0);
    tick();

`ifdef FIR_FEEDER_DECIM_EN
    // Decimation by 4: samples 0..15 forward 0,4,8,12
    bus.cfg_dec_level = 2'd2;
    exp_coeffs(1, 32'h60);
    exp_samples(16, 32'h0, 2);
    base_x = samp_xfers;
    pulse_cfg(6'd1);
    bus.cfg_dec_level = 2'd0;
    send_coeffs(1, 32'h60);
    push_samples(16, 32'h0);
    wait_drain("drain_decim");
    check("decim_count", 64'(samp_xfers - base_x), 64'd4);
`endif

    repeat (3) tick();
    check("error_sticky", 64'(bus.error_flag), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
